// File: rtl/addr_translator.sv
// Virtual-to-physical address translator: one-entry micro-TLB between a CPU
// port, an MMU page-table walker and a memory port, with fault reporting.
module addr_translator #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        paging_en,
    input  logic        flush_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_i,
    input  logic        cpu_rd_i,
    input  logic        cpu_we_i,
    output logic [31:0] cpu_data_o,
    output logic        cpu_ack_o,
    output logic [31:0] mmu_v_addr_o,
    output logic        mmu_lookup_o,
    input  logic [31:0] mmu_ent_i,
    input  logic        mmu_ack_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i,
    output logic        mem_rd_o,
    output logic        mem_we_o,
    input  logic        mem_ack_i,
    output logic        fault_o,
    output logic [31:0] fault_addr_o,
    output logic [1:0]  fault_cause_o
);
    localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_ACCESS,
        S_DONE,
        S_FAULT
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [31:0]       r_vaddr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_we;
    logic [19:0]       r_pfn;
    logic [WAIT_W-1:0] r_wait;
    logic [31:0]       r_fault_addr;
    logic [1:0]        r_fault_cause;
    logic              r_tlb_valid;
    logic              r_tlb_wr;
    logic [19:0]       r_tlb_vpn;
    logic [19:0]       r_tlb_pfn;
    logic              r_paging_q;

    logic              w_hit;
    logic              w_timeout;
    logic              w_flush;
    logic              w_req;
    logic              w_fill;
    logic [19:0]       w_pfn_next;
    logic [1:0]        w_fault_cause;
    logic [31:0]       w_fault_addr;
    logic              w_unused_pte;

    assign w_hit        = r_tlb_valid && (r_tlb_vpn == cpu_addr_i[31:12]);
    assign w_timeout    = (r_wait == WAIT_W'(TIMEOUT - 1));
    assign w_flush      = flush_i || (paging_en != r_paging_q);
    assign w_unused_pte = ^mmu_ent_i[11:2];

    always_comb begin
        w_state_next  = r_state;
        w_req         = 1'b0;
        w_fill        = 1'b0;
        w_pfn_next    = r_pfn;
        w_fault_cause = 2'd0;
        w_fault_addr  = r_vaddr;
        case (r_state)
            S_IDLE: begin
                if (cpu_rd_i || cpu_we_i) begin
                    w_req        = 1'b1;
                    w_fault_addr = cpu_addr_i;
                    if (!paging_en) begin
                        w_state_next = S_ACCESS;
                        w_pfn_next   = cpu_addr_i[31:12];
                    end else if (w_hit) begin
                        // Write-protect is resolved from the cached entry; no walk needed.
                        if (cpu_we_i && !r_tlb_wr) begin
                            w_state_next  = S_FAULT;
                            w_fault_cause = 2'd2;
                        end else begin
                            w_state_next = S_ACCESS;
                            w_pfn_next   = r_tlb_pfn;
                        end
                    end else begin
                        w_state_next = S_LOOKUP;
                    end
                end
            end
            S_LOOKUP: begin
                if (mmu_ack_i) begin
                    if (!mmu_ent_i[0]) begin
                        w_state_next  = S_FAULT;
                        w_fault_cause = 2'd1;
                    end else if (r_we && !mmu_ent_i[1]) begin
                        w_state_next  = S_FAULT;
                        w_fault_cause = 2'd2;
                    end else begin
                        w_state_next = S_ACCESS;
                        w_fill       = 1'b1;
                        w_pfn_next   = mmu_ent_i[31:12];
                    end
                end else if (w_timeout) begin
                    w_state_next  = S_FAULT;
                    w_fault_cause = 2'd3;
                end
            end
            S_ACCESS: begin
                if (mem_ack_i) begin
                    w_state_next = S_DONE;
                end else if (w_timeout) begin
                    w_state_next  = S_FAULT;
                    w_fault_cause = 2'd3;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            S_FAULT: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_vaddr       <= '0;
            r_wdata       <= '0;
            r_rdata       <= '0;
            r_we          <= 1'b0;
            r_pfn         <= '0;
            r_wait        <= '0;
            r_fault_addr  <= '0;
            r_fault_cause <= '0;
            r_tlb_valid   <= 1'b0;
            r_tlb_wr      <= 1'b0;
            r_tlb_vpn     <= '0;
            r_tlb_pfn     <= '0;
            r_paging_q    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pfn      <= w_pfn_next;
            r_paging_q <= paging_en;
            if (w_req) begin
                r_vaddr <= cpu_addr_i;
                r_wdata <= cpu_data_i;
                r_we    <= cpu_we_i;
            end
            // Any state change restarts the wait counter, so entry to LOOKUP/ACCESS starts at 0.
            if (w_state_next != r_state) begin
                r_wait <= '0;
            end else if (r_state == S_LOOKUP || r_state == S_ACCESS) begin
                r_wait <= r_wait + WAIT_W'(1);
            end
            if (r_state == S_ACCESS && mem_ack_i && !r_we) begin
                r_rdata <= mem_data_i;
            end
            if (w_state_next == S_FAULT) begin
                r_fault_addr  <= w_fault_addr;
                r_fault_cause <= w_fault_cause;
            end
            if (w_flush) begin
                r_tlb_valid <= 1'b0;
            end else if (w_fill) begin
                r_tlb_valid <= 1'b1;
                r_tlb_vpn   <= r_vaddr[31:12];
                r_tlb_pfn   <= mmu_ent_i[31:12];
                r_tlb_wr    <= mmu_ent_i[1];
            end
        end
    end

    always_comb begin
        cpu_data_o   = '0;
        cpu_ack_o    = 1'b0;
        mmu_v_addr_o = '0;
        mmu_lookup_o = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        mem_rd_o     = 1'b0;
        mem_we_o     = 1'b0;
        fault_o      = 1'b0;
        case (r_state)
            S_LOOKUP: begin
                mmu_lookup_o = 1'b1;
                mmu_v_addr_o = r_vaddr;
            end
            S_ACCESS: begin
                mem_addr_o = {r_pfn, r_vaddr[11:0]};
                mem_data_o = r_wdata;
                mem_we_o   = r_we;
                mem_rd_o   = ~r_we;
            end
            S_DONE: begin
                cpu_ack_o  = 1'b1;
                cpu_data_o = r_we ? '0 : r_rdata;
            end
            S_FAULT: begin
                cpu_ack_o = 1'b1;
                fault_o   = 1'b1;
            end
            default: ;
        endcase
    end

    assign fault_addr_o  = r_fault_addr;
    assign fault_cause_o = r_fault_cause;
endmodule

// File: tb/tb_addr_translator.sv
// Directed scoreboard bench for addr_translator: expectations are queued as
// requests are driven and checked when cpu_ack_o appears.
module tb_addr_translator;
    logic        clk = 1'b0;
    logic        rst;
    logic        paging_en;
    logic        flush_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_i;
    logic        cpu_rd_i;
    logic        cpu_we_i;
    logic [31:0] cpu_data_o;
    logic        cpu_ack_o;
    logic [31:0] mmu_v_addr_o;
    logic        mmu_lookup_o;
    logic [31:0] mmu_ent_i;
    logic        mmu_ack_i;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;
    logic        mem_rd_o;
    logic        mem_we_o;
    logic        mem_ack_i;
    logic        fault_o;
    logic [31:0] fault_addr_o;
    logic [1:0]  fault_cause_o;

    addr_translator #(.TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .paging_en(paging_en), .flush_i(flush_i),
        .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i), .cpu_rd_i(cpu_rd_i),
        .cpu_we_i(cpu_we_i), .cpu_data_o(cpu_data_o), .cpu_ack_o(cpu_ack_o),
        .mmu_v_addr_o(mmu_v_addr_o), .mmu_lookup_o(mmu_lookup_o),
        .mmu_ent_i(mmu_ent_i), .mmu_ack_i(mmu_ack_i),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
        .mem_rd_o(mem_rd_o), .mem_we_o(mem_we_o), .mem_ack_i(mem_ack_i),
        .fault_o(fault_o), .fault_addr_o(fault_addr_o), .fault_cause_o(fault_cause_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] mem_addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        fault;
        logic [1:0]  cause;
        logic [31:0] faddr;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    int unsigned req_cyc = 0;
    int          n_lookups = 0;
    int          n_overlap = 0;
    int          n_memwe = 0;
    logic        prev_lookup = 1'b0;
    logic [166:0] all_out;

    assign all_out = {cpu_data_o, cpu_ack_o, mmu_v_addr_o, mmu_lookup_o, mem_addr_o,
                      mem_data_o, mem_rd_o, mem_we_o, fault_o, fault_addr_o, fault_cause_o};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mmu_lookup_o && !prev_lookup) n_lookups++;
        prev_lookup = mmu_lookup_o;
        if (mmu_lookup_o && (mem_rd_o || mem_we_o)) n_overlap++;
        if (mem_we_o) n_memwe++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, observed no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [166:0] obs, input logic [166:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_ok(input logic [31:0] maddr, input logic we,
                           input logic [31:0] wdata, input logic [31:0] rdata);
        exp_t e;
        e.mem_addr = maddr; e.we = we; e.wdata = wdata; e.rdata = rdata;
        e.fault = 1'b0; e.cause = 2'd0; e.faddr = '0;
        sb.push_back(e);
    endtask

    task automatic push_fault(input logic [1:0] cause, input logic [31:0] faddr);
        exp_t e;
        e.mem_addr = '0; e.we = 1'b0; e.wdata = '0; e.rdata = '0;
        e.fault = 1'b1; e.cause = cause; e.faddr = faddr;
        sb.push_back(e);
    endtask

    task automatic cpu_req(input logic [31:0] a, input logic [31:0] d, input logic we);
        cpu_addr_i = a; cpu_data_i = d; cpu_we_i = we; cpu_rd_i = ~we;
        req_cyc = cyc;
        @(negedge clk);
        cpu_rd_i = 1'b0; cpu_we_i = 1'b0;
    endtask

    task automatic serve_mmu(input logic [31:0] pte, input logic [31:0] exp_va);
        int unsigned n = 0;
        while (!mmu_lookup_o && n < 50) begin @(negedge clk); n++; end
        check("mmu_lookup_seen", mmu_lookup_o, 1);
        check("mmu_v_addr", mmu_v_addr_o, exp_va);
        mmu_ent_i = pte; mmu_ack_i = 1'b1;
        @(negedge clk);
        mmu_ack_i = 1'b0; mmu_ent_i = '0;
    endtask

    task automatic serve_mem(input logic [31:0] rdata, input int unsigned lat);
        int unsigned n = 0;
        exp_t e;
        while (!(mem_rd_o || mem_we_o) && n < 50) begin @(negedge clk); n++; end
        check("mem_strobe_seen", mem_rd_o | mem_we_o, 1);
        check("sb_nonempty_mem", sb.size() != 0, 1);
        if (sb.size() != 0) begin
            e = sb[0];
            check("mem_addr", mem_addr_o, e.mem_addr);
            check("mem_we", mem_we_o, e.we);
            check("mem_rd", mem_rd_o, !e.we);
            if (e.we) check("mem_wdata", mem_data_o, e.wdata);
        end
        repeat (lat) @(negedge clk);
        mem_data_i = rdata; mem_ack_i = 1'b1;
        @(negedge clk);
        mem_ack_i = 1'b0; mem_data_i = '0;
    endtask

    task automatic wait_cpu_ack(input int unsigned budget, input int unsigned exp_lat);
        int unsigned n = 0;
        exp_t e;
        while (!cpu_ack_o && n < budget) begin @(negedge clk); n++; end
        check("cpu_ack_seen", cpu_ack_o, 1);
        check("sb_nonempty_ack", sb.size() != 0, 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("fault_o", fault_o, e.fault);
            check("cpu_data", cpu_data_o, (e.fault || e.we) ? 32'h0 : e.rdata);
            if (e.fault) begin
                check("fault_cause", fault_cause_o, e.cause);
                check("fault_addr", fault_addr_o, e.faddr);
            end
            if (exp_lat != 0) check("latency", cyc - req_cyc, exp_lat);
            @(negedge clk);
            check("ack_one_cycle", {cpu_ack_o, fault_o}, 0);
            if (e.fault) check("fault_hold", {fault_cause_o, fault_addr_o}, {e.cause, e.faddr});
        end
    endtask

    initial begin
        int lk;
        int we_cnt;
        int unsigned n;
        rst = 1'b0; paging_en = 1'b0; flush_i = 1'b0;
        cpu_addr_i = '0; cpu_data_i = '0; cpu_rd_i = 1'b0; cpu_we_i = 1'b0;
        mmu_ent_i = '0; mmu_ack_i = 1'b0; mem_data_i = '0; mem_ack_i = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", all_out, '0);
        rst = 1'b1;
        @(negedge clk);

        // Paging off read with minimum latency.
        push_ok(32'h0000_1234, 1'b0, '0, 32'hDEAD_BEEF);
        cpu_req(32'h0000_1234, '0, 1'b0);
        serve_mem(32'hDEAD_BEEF, 1);
        wait_cpu_ack(20, 3);

        // Paging on: miss -> one lookup, fills a writable entry.
        paging_en = 1'b1;
        lk = n_lookups;
        push_ok(32'h0008_8010, 1'b0, '0, 32'h1111_2222);
        cpu_req(32'h0040_3010, '0, 1'b0);
        serve_mmu(32'h0008_8003, 32'h0040_3010);
        serve_mem(32'h1111_2222, 1);
        wait_cpu_ack(20, 0);
        check("one_lookup", n_lookups - lk, 1);

        // Same page, last word: hit, no lookup, minimum latency.
        lk = n_lookups;
        push_ok(32'h0008_8FFC, 1'b0, '0, 32'h3333_4444);
        cpu_req(32'h0040_3FFC, '0, 1'b0);
        serve_mem(32'h3333_4444, 1);
        wait_cpu_ack(20, 3);
        check("hit_no_lookup", n_lookups - lk, 0);

        // Write through the writable entry.
        push_ok(32'h0008_8020, 1'b1, 32'hCAFE_F00D, '0);
        cpu_req(32'h0040_3020, 32'hCAFE_F00D, 1'b1);
        serve_mem(32'h5555_5555, 2);
        wait_cpu_ack(20, 0);

        // Flush, then refill the same page read-only.
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        lk = n_lookups;
        push_ok(32'h0008_8000, 1'b0, '0, 32'h0BAD_F00D);
        cpu_req(32'h0040_3000, '0, 1'b0);
        serve_mmu(32'h0008_8001, 32'h0040_3000);
        serve_mem(32'h0BAD_F00D, 1);
        wait_cpu_ack(20, 0);
        check("flush_forces_lookup", n_lookups - lk, 1);

        // Write to read-only cached entry: fault cause 2, no walk, no memory write.
        lk = n_lookups;
        we_cnt = n_memwe;
        push_fault(2'd2, 32'h0040_3000);
        cpu_req(32'h0040_3000, 32'h1234_5678, 1'b1);
        wait_cpu_ack(20, 0);
        check("wp_no_lookup", n_lookups - lk, 0);
        check("wp_no_mem_we", n_memwe - we_cnt, 0);

        // Not-present PTE.
        push_fault(2'd1, 32'h0050_0000);
        cpu_req(32'h0050_0000, '0, 1'b0);
        serve_mmu(32'h0000_0000, 32'h0050_0000);
        wait_cpu_ack(20, 0);

        // Write miss whose PTE is read-only.
        we_cnt = n_memwe;
        push_fault(2'd2, 32'h0060_0004);
        cpu_req(32'h0060_0004, 32'hAAAA_0000, 1'b1);
        serve_mmu(32'h0009_9001, 32'h0060_0004);
        wait_cpu_ack(20, 0);
        check("pte_wp_no_mem_we", n_memwe - we_cnt, 0);

        // Memory never acks: timeout after 255 cycles in ACCESS.
        paging_en = 1'b0;
        push_fault(2'd3, 32'h0000_2000);
        cpu_req(32'h0000_2000, '0, 1'b0);
        wait_cpu_ack(400, 256);

        // Reset during ACCESS on a hit, then the same access must miss.
        paging_en = 1'b1;
        push_ok(32'h0008_8010, 1'b0, '0, 32'h7777_8888);
        cpu_req(32'h0040_3010, '0, 1'b0);
        serve_mmu(32'h0008_8003, 32'h0040_3010);
        serve_mem(32'h7777_8888, 1);
        wait_cpu_ack(20, 0);
        lk = n_lookups;
        push_ok(32'h0008_8014, 1'b0, '0, '0);
        cpu_req(32'h0040_3014, '0, 1'b0);
        n = 0;
        while (!mem_rd_o && n < 20) begin @(negedge clk); n++; end
        check("pre_reset_access", {mem_rd_o, mem_addr_o}, {1'b1, 32'h0008_8014});
        check("pre_reset_hit", n_lookups - lk, 0);
        #2 rst = 1'b0;
        #1 check("async_reset_outputs", all_out, '0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        lk = n_lookups;
        push_ok(32'h0008_8010, 1'b0, '0, 32'h9999_0000);
        cpu_req(32'h0040_3010, '0, 1'b0);
        serve_mmu(32'h0008_8003, 32'h0040_3010);
        serve_mem(32'h9999_0000, 1);
        wait_cpu_ack(20, 0);
        check("post_reset_miss", n_lookups - lk, 1);

        check("strobe_overlap", n_overlap, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
